mult_div_unit: RTL

//  Parametrised multicycle signed multiply/divide unit feeding the CPU's HI and LO registers.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/md_sign_fix.sv | 19 +
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU multiply/divide unit: operation select and FSM states.
package cpu_pkg;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation: magnitude/abs in, sign-corrected value out.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // negate when requested, otherwise pass through
    always_comb begin
        if (neg) begin
            res = ~val + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit driving HI/LO.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    // MULT: {acc, multiplier, q(-1)}; DIV: {remainder(W+1), quotient(W)}
    logic [2*WIDTH:0]   prod_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               neg_q_r;
    logic               neg_r_r;

    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH:0]     acc_ext_s;
    logic [WIDTH:0]     mcand_ext_s;
    logic [WIDTH:0]     booth_sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     rem_diff_s;
    logic [2*WIDTH:0]   step_nxt_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(a), .neg(a[WIDTH-1]), .res(abs_a_s));
    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(b), .neg(b[WIDTH-1]), .res(abs_b_s));
    md_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.val(step_nxt_s[WIDTH-1:0]), .neg(neg_q_r), .res(quot_fix_s));
    md_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.val(step_nxt_s[2*WIDTH-1:WIDTH]), .neg(neg_r_r), .res(rem_fix_s));

    // one Booth or restoring-division step on the shared product register
    always_comb begin
        // accumulator is widened by one bit so that adding/subtracting MIN cannot overflow
        acc_ext_s   = {prod_r[2*WIDTH], prod_r[2*WIDTH:WIDTH+1]};
        mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
        case (prod_r[1:0])
            2'b01:   booth_sum_s = acc_ext_s + mcand_ext_s;
            2'b10:   booth_sum_s = acc_ext_s - mcand_ext_s;
            default: booth_sum_s = acc_ext_s;
        endcase
        rem_sh_s   = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        rem_diff_s = rem_sh_s - {1'b0, mcand_r};
        case (state_r)
            MD_MULT: step_nxt_s = {booth_sum_s, prod_r[WIDTH:1]};
            MD_DIV: begin
                if (rem_diff_s[WIDTH]) begin
                    step_nxt_s = {rem_sh_s, prod_r[WIDTH-2:0], 1'b0};
                end else begin
                    step_nxt_s = {rem_diff_s, prod_r[WIDTH-2:0], 1'b1};
                end
            end
            default: step_nxt_s = prod_r;
        endcase
    end

    // select the final HI/LO value for the step that completes the operation
    always_comb begin
        if (state_r == MD_MULT) begin
            res_hi_s = step_nxt_s[2*WIDTH:WIDTH+1];
            res_lo_s = step_nxt_s[WIDTH:1];
        end else begin
            res_hi_s = rem_fix_s;
            res_lo_s = quot_fix_s;
        end
    end

    // FSM, iteration counter, operand capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= MD_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            prod_r     <= {(2*WIDTH+1){1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    done_r     <= 1'b0;
                    div_zero_r <= 1'b0;
                    cnt_r      <= {CNT_W{1'b0}};
                    if (start) begin
                        neg_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r_r <= a[WIDTH-1];
                        if (op == MD_OP_MULT) begin
                            state_r <= MD_MULT;
                            busy_r  <= 1'b1;
                            prod_r  <= {{WIDTH{1'b0}}, b, 1'b0};
                            mcand_r <= a;
                        end else if (b == {WIDTH{1'b0}}) begin
                            // divide-by-zero: report immediately, HI/LO untouched
                            state_r    <= MD_DONE;
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                        end else begin
                            state_r <= MD_DIV;
                            busy_r  <= 1'b1;
                            prod_r  <= {{(WIDTH+1){1'b0}}, abs_a_s};
                            mcand_r <= abs_b_s;
                        end
                    end
                end
                MD_MULT, MD_DIV: begin
                    prod_r <= step_nxt_s;
                    cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        state_r <= MD_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        hi_r    <= res_hi_s;
                        lo_r    <= res_lo_s;
                    end
                end
                MD_DONE: begin
                    state_r    <= MD_IDLE;
                    done_r     <= 1'b0;
                    div_zero_r <= 1'b0;
                end
                default: begin
                    state_r <= MD_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule
